iomem_arbiter: RTL and testbench
================================

// Module: iomem_arbiter
// PURPOSE
//  Two-master arbiter for the single-port memory-mapped I/O space (RAM, VRAM, PS2, VSync regs).
//  Sits between the iomemory slave port and two requesters:
//   - m0: ARM core load/store path.
//   - m1: frame-copy engine (RAM -> VRAM).
//  Accepts one single-beat access per cycle and registers the winning request onto the slave port.
//  Returns read data to the issuing master with its original order preserved.
//  During vertical blank, m1 gets priority, bounded by a burst limit so the core is never starved.
// PARAMETERS
//  ADDR_W     32  address width, both masters and slave
//  DATA_W     32  data width, both masters and slave
//  READ_LAT    1  cycles from s_address driven to s_rdata valid (1..4)
//  MAX_BURST   4  max consecutive m1 grants during vblank while m0 is waiting (1..15)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       asynchronous, active-low reset
//  vblank      in   1       high during vertical blank (synchronous to clk)
//  mX_req      in   1       X=0,1: access request; hold with mX_we/addr/wdata stable until mX_gnt
//  mX_we       in   1       X=0,1: 1 = write, 0 = read
//  mX_addr     in   ADDR_W  X=0,1: byte address
//  mX_wdata    in   DATA_W  X=0,1: write data
//  mX_gnt      out  1       X=0,1: request accepted this cycle (combinational from req + arb state)
//  mX_rvalid   out  1       X=0,1: one-cycle pulse, mX_rdata valid
//  mX_rdata    out  DATA_W  X=0,1: read data
//  s_we        out  1       slave write enable, registered
//  s_address   out  ADDR_W  slave address, registered
//  s_wdata     out  DATA_W  slave write data, registered
//  s_rdata     in   DATA_W  slave read data, valid READ_LAT cycles after s_address
// BEHAVIOUR
//  Reset (rst=0, async)
//   - s_we, s_address, s_wdata, mX_gnt, mX_rvalid, mX_rdata = 0.
//   - FSM = IDLE, rr_ptr = m0, burst_cnt = 0, read-tag pipeline cleared.
//  Arbitration, every cycle; exactly one or zero gnt per cycle:
//   - Neither master requests: no gnt.
//   - Exactly one master requests: that master is granted.
//   - Both request, vblank=1, burst_cnt < MAX_BURST: m1 granted.
//   - Both request, vblank=1, burst_cnt == MAX_BURST: m0 granted, burst_cnt -> 0.
//   - Both request, vblank=0: round-robin; rr_ptr master wins, rr_ptr then toggles.
//  burst_cnt
//   - Increments on each m1 grant while m0_req=1 and vblank=1; saturates at MAX_BURST.
//   - Clears on any m0 grant, any cycle with m0_req=0, or vblank=0.
//  FSM (state = last owner): IDLE, OWN0, OWN1.
//   - Transitions to OWNx on a gnt to x; to IDLE on a cycle with no gnt.
//   - rr_ptr updates only on contended grants.
//  Issue: gnt in cycle N -> s_address/s_wdata/s_we registered at edge ending N, valid in N+1.
//   - s_we = 1 for exactly one cycle per granted write; 0 otherwise.
//   - s_address and s_wdata hold their last values when idle.
//  Read return
//   - Tag pipeline of depth READ_LAT+1 carries {valid, master id}.
//   - Read granted in N gives mX_rvalid=1 and mX_rdata=s_rdata (registered) in cycle N+1+READ_LAT.
//   - Back-to-back reads from mixed masters return in issue order, one per cycle, no bubbles.
//   - Writes generate no rvalid.
//   - mX_rdata holds its last value when rvalid=0.
//  Boundary conditions
//   - vblank falls mid-burst: the next contended cycle uses round-robin from current rr_ptr.
//   - Reset mid-operation: in-flight reads discarded (no rvalid after rst deasserts); no s_we glitch.
//   - A master dropping req before gnt is legal; the request is simply not issued.
// TESTING
//  1. Reset: rst=0 mid-read (m0 read A=0x10 granted) -> after release: no m0_rvalid; all outputs 0.
//  2. Single master: m0 read 0x20 at N -> m0_gnt@N, s_address=0x20@N+1, m0_rvalid@N+2 (READ_LAT=1).
//  3. Contention, vblank=0: both request 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1.
//  4. Contention, vblank=1, MAX_BURST=4 -> grant order m1 x4, m0, m1 x4, m0.
//  5. Mixed pipelined reads: m0@0x4, m1@0x8, m0@0xC consecutive -> rvalid m0,m1,m0 on consecutive cycles with matching data.
//  6. Write: m1 write 0x100 <= 0xDEADBEEF -> s_we=1 for exactly one cycle with that addr/data; no m1_rvalid.

Source files
------------

// File: rtl/iomem_arbiter.sv
// Two-master arbiter for the memory-mapped I/O slave port: registered issue,
// vblank-biased priority for the frame-copy engine, in-order read return.
module iomem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vblank,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t              state_q, state_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [3:0]          burst_cnt_q, burst_cnt_d;
  logic                gnt0, gnt1;
  logic                s_we_q;
  logic [ADDR_W-1:0]   s_address_q;
  logic [DATA_W-1:0]   s_wdata_q;
  logic [READ_LAT-1:0] tag_v0_q, tag_v1_q, tag_v0_d, tag_v1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;
  logic                rd0_v0, rd0_v1;

  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (m0_req && m1_req) begin
      if (vblank) begin
        if (burst_cnt_q < MAX_B) gnt1 = 1'b1;
        else                     gnt0 = 1'b1;
      end else begin
        gnt0     = ~rr_ptr_q;
        gnt1     = rr_ptr_q;
        rr_ptr_d = ~rr_ptr_q;
      end
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end
    if (!vblank || !m0_req || gnt0)
      burst_cnt_d = 4'd0;
    else if (gnt1 && burst_cnt_q < MAX_B)
      burst_cnt_d = burst_cnt_q + 4'd1;
    state_d = gnt0 ? OWN0 : (gnt1 ? OWN1 : IDLE);
  end

  // The owner state plus the registered write flag form stage 0 of the read-tag
  // pipeline; per-master one-hot shift registers carry the remaining stages.
  assign rd0_v0   = (state_q == OWN0) && !s_we_q;
  assign rd0_v1   = (state_q == OWN1) && !s_we_q;
  assign tag_v0_d = (tag_v0_q << 1) | READ_LAT'(rd0_v0);
  assign tag_v1_d = (tag_v1_q << 1) | READ_LAT'(rd0_v1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= 4'd0;
      s_we_q      <= 1'b0;
      s_address_q <= '0;
      s_wdata_q   <= '0;
      tag_v0_q    <= '0;
      tag_v1_q    <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tag_v0_q    <= tag_v0_d;
      tag_v1_q    <= tag_v1_d;
      if (gnt0) begin
        s_we_q      <= m0_we;
        s_address_q <= m0_addr;
        s_wdata_q   <= m0_wdata;
      end else if (gnt1) begin
        s_we_q      <= m1_we;
        s_address_q <= m1_addr;
        s_wdata_q   <= m1_wdata;
      end else begin
        s_we_q      <= 1'b0;
      end
      if (tag_v0_d[READ_LAT-1]) rdata0_q <= s_rdata;
      if (tag_v1_d[READ_LAT-1]) rdata1_q <= s_rdata;
    end
  end

  // Grants are suppressed while reset is held so nothing is accepted then.
  assign m0_gnt    = gnt0 & rst;
  assign m1_gnt    = gnt1 & rst;
  assign m0_rvalid = tag_v0_q[READ_LAT-1];
  assign m1_rvalid = tag_v1_q[READ_LAT-1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign s_we      = s_we_q;
  assign s_address = s_address_q;
  assign s_wdata   = s_wdata_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter: expected grants per cycle, a slave-port
// model and a read-return scoreboard keyed by the cycle each read is due.
module tb_iomem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vblank = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, s_we;
  logic [DW-1:0] m0_rdata, m1_rdata, s_wdata, s_rdata;
  logic [AW-1:0] s_address;

  iomem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_we(s_we), .s_address(s_address), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_val(logic [AW-1:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  // Slave answers within the cycle its address is presented (READ_LAT = 1).
  assign s_rdata = mem_val(s_address);

  typedef struct {
    int            due;
    bit            id;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc_n = 0;
  logic          exp_swe = 1'b0;
  logic [AW-1:0] exp_sa = '0;
  logic [DW-1:0] exp_swd = '0;
  logic [DW-1:0] last0 = '0, last1 = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit eg0, input bit eg1);
    bit e0, e1;
    exp_t ent;
    @(negedge clk);
    chk("m0_gnt", DW'(m0_gnt), DW'(eg0));
    chk("m1_gnt", DW'(m1_gnt), DW'(eg1));
    chk("s_we", DW'(s_we), DW'(exp_swe));
    chk("s_address", s_address, exp_sa);
    chk("s_wdata", s_wdata, exp_swd);
    e0 = 1'b0;
    e1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      e0 = !sb[0].id;
      e1 = sb[0].id;
      if (e0) last0 = sb[0].data;
      if (e1) last1 = sb[0].data;
      void'(sb.pop_front());
    end
    chk("m0_rvalid", DW'(m0_rvalid), DW'(e0));
    chk("m1_rvalid", DW'(m1_rvalid), DW'(e1));
    chk("m0_rdata", m0_rdata, last0);
    chk("m1_rdata", m1_rdata, last1);
    if (eg0) begin
      exp_swe = m0_we; exp_sa = m0_addr; exp_swd = m0_wdata;
      if (!m0_we) begin
        ent.due = cyc_n + 1 + RL; ent.id = 1'b0; ent.data = mem_val(m0_addr);
        sb.push_back(ent);
      end
    end else if (eg1) begin
      exp_swe = m1_we; exp_sa = m1_addr; exp_swd = m1_wdata;
      if (!m1_we) begin
        ent.due = cyc_n + 1 + RL; ent.id = 1'b1; ent.data = mem_val(m1_addr);
        sb.push_back(ent);
      end
    end else begin
      exp_swe = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  initial begin
    // Reset state while held
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0);
    rst = 1'b1;
    cyc(0, 0);

    // Single master read: grant N, address N+1, rvalid N+2
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h20;
    cyc(1, 0);
    m0_req = 1'b0;
    repeat (3) cyc(0, 0);

    // Reset while a read is in flight
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    cyc(1, 0);
    m0_req = 1'b0;
    rst = 1'b0;
    sb.delete();
    exp_swe = 1'b0; exp_sa = '0; exp_swd = '0; last0 = '0; last1 = '0;
    cyc(0, 0);
    rst = 1'b1;
    repeat (3) cyc(0, 0);

    // Round-robin contention outside vblank
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h0000_0055;
    repeat (3) begin
      cyc(1, 0);
      cyc(0, 1);
    end

    // Vblank bias: m1 x4 then m0, twice; then vblank falls mid-burst
    vblank = 1'b1;
    m0_we = 1'b1; m0_addr = 32'h60; m0_wdata = 32'hCAFE_0001;
    m1_we = 1'b0; m1_addr = 32'h64;
    repeat (2) begin
      repeat (MB) cyc(0, 1);
      cyc(1, 0);
    end
    repeat (2) cyc(0, 1);
    vblank = 1'b0;
    cyc(1, 0);
    cyc(0, 1);
    m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) cyc(0, 0);

    // Pipelined reads from mixed masters
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;
    cyc(1, 0);
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    cyc(0, 1);
    m1_req = 1'b0;
    m0_req = 1'b1; m0_addr = 32'hC;
    cyc(1, 0);
    m0_req = 1'b0;
    repeat (3) cyc(0, 0);

    // Single write from m1
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'hDEAD_BEEF;
    cyc(0, 1);
    m1_req = 1'b0;
    repeat (3) cyc(0, 0);

    chk("sb_empty", DW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
